// File: rtl/ahb_rect_fill_pkg.sv
// Shared types and constants for the AHB-Lite rectangle fill master.
// Contents: AHB encodings, framebuffer geometry defaults, FSM state enum,
// rectangle command payload and the row-offset helper (no multiplier).
// Optional feature macro used by the design: AHB_RECT_FILL_CLIP_EN.
package ahb_rect_fill_pkg;

    localparam int unsigned X_W      = 10;
    localparam int unsigned Y_W      = 9;
    localparam int unsigned COLOUR_W = 8;
    localparam int unsigned ADDR_W   = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    localparam logic [ADDR_W-1:0] FB_BASE_DEFAULT  = 32'h2000_0000;
    localparam int unsigned       H_RES_DEFAULT    = 640;
    localparam int unsigned       V_RES_DEFAULT    = 480;
    localparam logic [ADDR_W-1:0] ROW_STRIDE_BYTES = 32'd2560;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ADDR,
        DATA_LAST,
        DONE
    } state_t;

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [X_W-1:0]      w;
        logic [Y_W-1:0]      h;
        logic [COLOUR_W-1:0] colour;
    } rect_cmd_t;

    // Byte offset of row y: y*640 pixels as (y<<9)+(y<<7), times 4 bytes.
    function automatic logic [ADDR_W-1:0] row_offset_bytes(input logic [Y_W-1:0] y);
        logic [ADDR_W-1:0] pix;
        pix = (ADDR_W'(y) << 9) + (ADDR_W'(y) << 7);
        return pix << 2;
    endfunction

endpackage

// File: rtl/ahb_rect_fill_master_addr_gen.sv
// rect_addr_gen: walks the pixel addresses of a rectangle row by row.
// Ports: HCLK/HRESET (sync active-high), load (latch origin/extent and
// first address), advance (address phase accepted), x/y origin, w/h
// effective extent; addr = current pixel address, last_in_row/last_beat
// flags describing the pixel currently presented on addr.
module rect_addr_gen
    import ahb_rect_fill_pkg::*;
#(
    parameter logic [ADDR_W-1:0] FB_BASE = FB_BASE_DEFAULT
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              load,
    input  logic              advance,
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    input  logic [X_W-1:0]    w,
    input  logic [Y_W-1:0]    h,
    output logic [ADDR_W-1:0] addr,
    output logic              last_in_row,
    output logic              last_beat
);

    logic [X_W-1:0]    col;
    logic [Y_W-1:0]    row;
    logic [X_W-1:0]    w_q;
    logic [Y_W-1:0]    h_q;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] x_off;

    // Flags are computed one step ahead so they describe the pixel on addr.
    // The walk freezes on the last beat so addr stays put through DATA_LAST.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            col         <= '0;
            row         <= '0;
            w_q         <= '0;
            h_q         <= '0;
            row_base    <= '0;
            x_off       <= '0;
            addr        <= '0;
            last_in_row <= 1'b0;
            last_beat   <= 1'b0;
        end else if (load) begin
            col         <= '0;
            row         <= '0;
            w_q         <= w;
            h_q         <= h;
            x_off       <= ADDR_W'(x) << 2;
            row_base    <= FB_BASE + row_offset_bytes(y);
            addr        <= FB_BASE + row_offset_bytes(y) + (ADDR_W'(x) << 2);
            last_in_row <= (w == X_W'(1));
            last_beat   <= (w == X_W'(1)) && (h == Y_W'(1));
        end else if (advance && !last_beat) begin
            if (last_in_row) begin
                col         <= '0;
                row         <= row + Y_W'(1);
                row_base    <= row_base + ROW_STRIDE_BYTES;
                addr        <= row_base + ROW_STRIDE_BYTES + x_off;
                last_in_row <= (w_q == X_W'(1));
                last_beat   <= (w_q == X_W'(1)) && (row + Y_W'(2) == h_q);
            end else begin
                col         <= col + X_W'(1);
                addr        <= addr + ADDR_W'(4);
                last_in_row <= (col + X_W'(2) == w_q);
                last_beat   <= (col + X_W'(2) == w_q) && (row + Y_W'(1) == h_q);
            end
        end
    end

endmodule

// File: rtl/ahb_rect_fill_master.sv
// AHB-Lite initiator filling an axis-aligned framebuffer rectangle with a
// constant 8-bit colour, one single-word write per pixel.
// Ports: HCLK, HRESET (sync active-high); cmd_valid/cmd_ready handshake with
// cmd_x/cmd_y/cmd_w/cmd_h/cmd_colour; AHB master HADDR/HTRANS/HWRITE/HSIZE/
// HWDATA with HREADY/HRESP; status busy, done (1-cycle pulse), err (sticky).
// Macro AHB_RECT_FILL_CLIP_EN: defined clips to screen; undefined rejects
// any off-screen rectangle with err.
module ahb_rect_fill_master
    import ahb_rect_fill_pkg::*;
#(
    parameter logic [ADDR_W-1:0] FB_BASE = FB_BASE_DEFAULT,
    parameter int unsigned       H_RES   = H_RES_DEFAULT,
    parameter int unsigned       V_RES   = V_RES_DEFAULT
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [X_W-1:0]      cmd_x,
    input  logic [Y_W-1:0]      cmd_y,
    input  logic [X_W-1:0]      cmd_w,
    input  logic [Y_W-1:0]      cmd_h,
    input  logic [COLOUR_W-1:0] cmd_colour,
    output logic [ADDR_W-1:0]   HADDR,
    output logic [1:0]          HTRANS,
    output logic                HWRITE,
    output logic [2:0]          HSIZE,
    output logic [31:0]         HWDATA,
    input  logic                HREADY,
    input  logic                HRESP,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam logic [X_W:0] H_RES_L = (X_W + 1)'(H_RES);
    localparam logic [Y_W:0] V_RES_L = (Y_W + 1)'(V_RES);

    state_t    state;
    rect_cmd_t cmd_q;

    logic [X_W-1:0] eff_w;
    logic [Y_W-1:0] eff_h;
    logic           reject;
    logic           zero_area;
    logic           gen_load;
    logic           gen_advance;
    logic           last_in_row;
    logic           last_beat;

    assign HSIZE = HSIZE_WORD;

    // Effective extent of the latched command, evaluated during SETUP.
    always_comb begin
        eff_w  = cmd_q.w;
        eff_h  = cmd_q.h;
        reject = 1'b0;
`ifdef AHB_RECT_FILL_CLIP_EN
        if ((X_W + 1)'(cmd_q.x) >= H_RES_L)
            eff_w = '0;
        else if ((X_W + 1)'(cmd_q.w) > H_RES_L - (X_W + 1)'(cmd_q.x))
            eff_w = X_W'(H_RES_L - (X_W + 1)'(cmd_q.x));
        if ((Y_W + 1)'(cmd_q.y) >= V_RES_L)
            eff_h = '0;
        else if ((Y_W + 1)'(cmd_q.h) > V_RES_L - (Y_W + 1)'(cmd_q.y))
            eff_h = Y_W'(V_RES_L - (Y_W + 1)'(cmd_q.y));
`else
        reject = ((X_W + 1)'(cmd_q.x) + (X_W + 1)'(cmd_q.w) > H_RES_L) ||
                 ((Y_W + 1)'(cmd_q.y) + (Y_W + 1)'(cmd_q.h) > V_RES_L);
`endif
        zero_area = (eff_w == '0) || (eff_h == '0);
    end

    assign gen_load    = (state == SETUP);
    assign gen_advance = (state == ADDR) && HREADY;

    // HADDR comes straight from the generator's address register.
    rect_addr_gen #(
        .FB_BASE (FB_BASE)
    ) u_addr_gen (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .load        (gen_load),
        .advance     (gen_advance),
        .x           (cmd_q.x),
        .y           (cmd_q.y),
        .w           (eff_w),
        .h           (eff_h),
        .addr        (HADDR),
        .last_in_row (last_in_row),
        .last_beat   (last_beat)
    );

    // Command FSM; all bus and status outputs are registered here.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= IDLE;
            cmd_q     <= '0;
            HTRANS    <= HTRANS_IDLE;
            HWRITE    <= 1'b0;
            HWDATA    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_q     <= '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, colour: cmd_colour};
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (reject || zero_area) begin
                        err   <= reject;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        HTRANS <= HTRANS_NONSEQ;
                        HWRITE <= 1'b1;
                        state  <= ADDR;
                    end
                end
                ADDR: begin
                    // First error cycle: drop the pending address phase.
                    if (HRESP && !HREADY) begin
                        HTRANS <= HTRANS_IDLE;
                        HWRITE <= 1'b0;
                        err    <= 1'b1;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (HREADY) begin
                        HWDATA <= {24'h0, cmd_q.colour};
                        if (last_beat) begin
                            HTRANS <= HTRANS_IDLE;
                            HWRITE <= 1'b0;
                            state  <= DATA_LAST;
                        end
                    end
                end
                DATA_LAST: begin
                    if (HRESP && !HREADY) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (HREADY) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_rect_fill_master.sv
// Self-checking bench for ahb_rect_fill_master: directed and random
// rectangles against an arithmetic reference of the expected pixel
// addresses, with a simple AHB slave model (stalls and error responses).
// Honours AHB_RECT_FILL_CLIP_EN for the reference clipping rules.
module tb_ahb_rect_fill_master;

    localparam logic [31:0] FB       = 32'h2000_0000;
    localparam logic [1:0]  T_IDLE   = 2'b00;
    localparam logic [1:0]  T_NONSEQ = 2'b10;

    logic        HCLK;
    logic        HRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_x;
    logic [8:0]  cmd_y;
    logic [9:0]  cmd_w;
    logic [8:0]  cmd_h;
    logic [7:0]  cmd_colour;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_mis = 0;

    ahb_rect_fill_master dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_w      (cmd_w),
        .cmd_h      (cmd_h),
        .cmd_colour (cmd_colour),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HWRITE     (HWRITE),
        .HSIZE      (HSIZE),
        .HWDATA     (HWDATA),
        .HREADY     (HREADY),
        .HRESP      (HRESP),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // stall_mode: 0 HREADY high, 1 random stalls, 2 three stall cycles on beat 1.
    // err_beat: data phase index that receives an ERROR response (-1 none).
    task automatic run_cmd(input int x, input int y, input int w, input int h,
                           input logic [7:0] col, input int stall_mode, input int err_beat);
        int          ew, eh;
        bit          rej, exp_err;
        logic [31:0] exp_q[$];
        logic [31:0] obs_q[$];
        int          cyc, first, last, done_cyc, beats, pend_idx, ephase, stall_left;
        bit          pend, held_valid, hr, rs;
        logic [31:0] held_addr;

        // Reference: pixels of the on-screen rectangle in raster order.
        rej = 0;
`ifdef AHB_RECT_FILL_CLIP_EN
        ew = (x >= 640) ? 0 : ((w < 640 - x) ? w : 640 - x);
        eh = (y >= 480) ? 0 : ((h < 480 - y) ? h : 480 - y);
`else
        rej = (x + w > 640) || (y + h > 480);
        ew  = w;
        eh  = h;
`endif
        if (!rej)
            for (int r = 0; r < eh; r++)
                for (int c = 0; c < ew; c++)
                    exp_q.push_back(FB + 32'(((y + r) * 640 + x + c) * 4));
        exp_err = rej;
        if (err_beat >= 0 && err_beat < exp_q.size()) begin
            while (exp_q.size() > err_beat + 1) void'(exp_q.pop_back());
            exp_err = 1;
        end else begin
            err_beat = -1;
        end

        @(negedge HCLK);
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_x      = 10'(x);
        cmd_y      = 9'(y);
        cmd_w      = 10'(w);
        cmd_h      = 9'(h);
        cmd_colour = col;
        cmd_valid  = 1'b1;
        HREADY     = 1'b1;
        HRESP      = 1'b0;

        cyc = 0; first = -1; last = -1; done_cyc = -1; beats = 0; pend_idx = 0;
        ephase = 0; stall_left = 3; pend = 0; held_valid = 0; held_addr = '0;
        while (done_cyc < 0 && cyc < 4000) begin
            @(negedge HCLK);
            cyc++;
            if (cyc == 1) begin
                chk("busy_after_accept", 32'(busy), 32'd1);
                chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
                chk("err_cleared_on_accept", 32'(err), 32'd0);
            end
            hr = 1; rs = 0;
            if (ephase == 1) begin
                rs = 1; ephase = 2;
                chk("htrans_after_err", 32'(HTRANS), 32'(T_IDLE));
            end else if (pend && ephase == 0 && err_beat >= 0 && pend_idx == err_beat) begin
                hr = 0; rs = 1; ephase = 1;
            end else if (stall_mode == 1) begin
                hr = ($urandom_range(0, 3) != 0);
            end else if (stall_mode == 2 && beats == 1 && stall_left > 0) begin
                hr = 0; stall_left--;
            end
            HREADY = hr;
            HRESP  = rs;
            if (held_valid) chk("haddr_hold", HADDR, held_addr);
            if (pend) chk("hwdata", HWDATA, {24'h0, col});
            if (HTRANS == T_NONSEQ) begin
                chk("hwrite_nonseq", 32'(HWRITE), 32'd1);
                chk("hsize", 32'(HSIZE), 32'd2);
                if (first < 0) first = cyc;
                last = cyc;
            end else begin
                chk("hwrite_idle", 32'(HWRITE), 32'd0);
            end
            if (hr) begin
                pend = 0;
                if (HTRANS == T_NONSEQ) begin
                    obs_q.push_back(HADDR);
                    pend = 1; pend_idx = beats; beats++;
                end
            end
            held_valid = (HTRANS == T_NONSEQ) && !hr && !rs;
            held_addr  = HADDR;
            if (done) done_cyc = cyc;
            // cmd_* must be ignored while busy
            cmd_valid  = (done_cyc < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            cmd_x      = 10'($urandom);
            cmd_y      = 9'($urandom);
            cmd_w      = 10'($urandom);
            cmd_h      = 9'($urandom);
            cmd_colour = 8'($urandom);
        end

        chk("done_seen", 32'(done_cyc >= 0), 32'd1);
        chk("err_at_done", 32'(err), 32'(exp_err));
        chk("beat_count", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk("haddr_seq", obs_q[i], exp_q[i]);
        if (stall_mode == 0 && err_beat < 0) begin
            if (exp_q.size() > 0) begin
                chk("first_nonseq_lat", 32'(first), 32'd2);
                chk("nonseq_run", 32'(last - first + 1), 32'(exp_q.size()));
                chk("done_lat", 32'(done_cyc), 32'(last + 2));
            end else begin
                chk("zero_done_lat", 32'(done_cyc), 32'd2);
            end
        end

        HREADY = 1'b1;
        HRESP  = 1'b0;
        @(negedge HCLK);
        chk("done_pulse_end", 32'(done), 32'd0);
        chk("busy_end", 32'(busy), 32'd0);
        chk("cmd_ready_end", 32'(cmd_ready), 32'd1);
        chk("err_sticky", 32'(err), 32'(exp_err));
        chk("htrans_end", 32'(HTRANS), 32'(T_IDLE));
    endtask

    initial begin
        int rx, ry, rw, rh, sm, eb;

        HRESET = 1'b1; cmd_valid = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_colour = '0;
        repeat (2) @(negedge HCLK);
        chk("rst_htrans", 32'(HTRANS), 32'(T_IDLE));
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hwrite", 32'(HWRITE), 32'd0);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        HRESET = 1'b0;

        // Directed cases
        run_cmd(0, 0, 4, 1, 8'hA5, 0, -1);
        run_cmd(638, 1, 2, 2, 8'h3C, 0, -1);
        run_cmd(0, 0, 4, 1, 8'hA5, 2, -1);
        run_cmd(5, 5, 0, 3, 8'h11, 0, -1);
        run_cmd(5, 5, 3, 0, 8'h12, 0, -1);
`ifdef AHB_RECT_FILL_CLIP_EN
        run_cmd(700, 10, 5, 2, 8'h22, 0, -1);
        run_cmd(636, 478, 8, 4, 8'h33, 0, -1);
`else
        run_cmd(636, 0, 8, 1, 8'h22, 0, -1);
        run_cmd(0, 478, 1, 3, 8'h33, 0, -1);
`endif
        run_cmd(639, 479, 1, 1, 8'h44, 0, -1);
        run_cmd(100, 50, 10, 1, 8'h5A, 0, 2);
        run_cmd(100, 50, 3, 2, 8'h6B, 0, -1);
        run_cmd(20, 30, 3, 2, 8'h7C, 0, 5);

        // Reset in the middle of a fill
        @(negedge HCLK);
        cmd_x = 10'd10; cmd_y = 9'd3; cmd_w = 10'd20; cmd_h = 9'd2;
        cmd_colour = 8'h99; cmd_valid = 1'b1;
        @(negedge HCLK);
        cmd_valid = 1'b0;
        repeat (5) @(negedge HCLK);
        chk("midfill_nonseq", 32'(HTRANS), 32'(T_NONSEQ));
        HRESET = 1'b1;
        @(negedge HCLK);
        chk("midrst_htrans", 32'(HTRANS), 32'(T_IDLE));
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("midrst_haddr", HADDR, 32'h0);
        chk("midrst_done", 32'(done), 32'd0);
        HRESET = 1'b0;
        run_cmd(10, 3, 5, 2, 8'hC3, 0, -1);

        // Randomised commands, biased toward the screen edges
        for (int k = 0; k < 24; k++) begin
`ifdef AHB_RECT_FILL_CLIP_EN
            rx = ($urandom_range(0, 1) != 0) ? int'($urandom_range(600, 700)) : int'($urandom_range(0, 639));
            ry = ($urandom_range(0, 1) != 0) ? int'($urandom_range(440, 500)) : int'($urandom_range(0, 479));
`else
            rx = ($urandom_range(0, 1) != 0) ? int'($urandom_range(600, 639)) : int'($urandom_range(0, 639));
            ry = ($urandom_range(0, 1) != 0) ? int'($urandom_range(440, 479)) : int'($urandom_range(0, 479));
`endif
            rw = int'($urandom_range(0, 12));
            rh = int'($urandom_range(0, 4));
            sm = int'($urandom_range(0, 1));
            eb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 5)) : -1;
            run_cmd(rx, ry, rw, rh, 8'($urandom), sm, eb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
